chan_cmd_processor: RTL and testbench

Parametrised successor to the single-channel UART command processor. It consumes bytes from the UART receiver and decodes a 2-bit-opcode command protocol into a NUM_CH x NUM_REG register file. It supports auto-incrementing writes, multi-register read-back through a TX valid/ready handshake, and a switch/button browse path that feeds the 7-segment display. It sits between uart_rx / uart_tx and the display driver in top.

---
 rtl/chan_pkg.sv | 30 +++
 rtl/chan_regfile.sv | 40 ++++
 rtl/chan_cmd_processor.sv | 250 +++++++++++++++++++++++++
 tb/tb_chan_cmd_processor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// chan_pkg: shared definitions for the channel command processor.
//   - command opcodes (byte[7:6])
//   - FSM state encoding (ST_WRITE_ACK only when WRITE_ACK_EN is defined)
//   - idx_w(): index width helper (clog2, minimum 1). The top derives
//     CH_W = idx_w(NUM_CH) and REG_W = idx_w(NUM_REG) from it.
// Optional feature macro: WRITE_ACK_EN
package chan_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_SEL_CH  = 2'b01;
    localparam logic [1:0] OP_SEL_REG = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_DATA   = 2'd1,
`ifdef WRITE_ACK_EN
        ST_READ_STREAM = 2'd2,
        ST_WRITE_ACK   = 2'd3
`else
        ST_READ_STREAM = 2'd2
`endif
    } state_t;

    // A 1-entry dimension still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_regfile.sv
// chan_regfile: NUM_CH x NUM_REG x 8-bit register storage.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all)
//   we, wr_ch, wr_reg,  one synchronous write port
//   wr_data
//   a_ch, a_reg, a_data read port A (TX path), combinational
//   b_ch, b_reg, b_data read port B (display path), combinational
module chan_regfile #(
    parameter int NUM_CH  = 4,
    parameter int NUM_REG = 8,
    parameter int CH_W    = 2,
    parameter int REG_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [REG_W-1:0] wr_reg,
    input  logic [7:0]       wr_data,
    input  logic [CH_W-1:0]  a_ch,
    input  logic [REG_W-1:0] a_reg,
    output logic [7:0]       a_data,
    input  logic [CH_W-1:0]  b_ch,
    input  logic [REG_W-1:0] b_reg,
    output logic [7:0]       b_data
);

    logic [NUM_CH-1:0][NUM_REG-1:0][7:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[wr_ch][wr_reg] <= wr_data;
    end

    assign a_data = mem[a_ch][a_reg];
    assign b_data = mem[b_ch][b_reg];

endmodule

// File: rtl/chan_cmd_processor.sv
// chan_cmd_processor: decodes a 2-bit-opcode byte protocol from uart_rx into
// a NUM_CH x NUM_REG register file, streams read-back bytes to uart_tx over a
// valid/ready handshake, and provides a button-driven browse view for the
// 7-segment display.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   rx_data, rx_valid, rx_parity_err  received byte stream
//   tx_data, tx_valid, tx_ready     read-back stream (held until accepted)
//   btn_next, browse_reg            browse controls
//   cur_ch, cur_reg                 protocol channel / register pointer
//   disp_ch, disp_reg, disp_data    browse pointers and registered value
//   err_count                       saturating error counter
//   busy                            streaming (or acking a write)
// Optional feature macro: WRITE_ACK_EN (echo each written byte on tx).
module chan_cmd_processor
    import chan_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_REG     = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int ERR_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_parity_err,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic                       btn_next,
    input  logic                       browse_reg,
    output logic [idx_w(NUM_CH)-1:0]   cur_ch,
    output logic [idx_w(NUM_REG)-1:0]  cur_reg,
    output logic [idx_w(NUM_CH)-1:0]   disp_ch,
    output logic [idx_w(NUM_REG)-1:0]  disp_reg,
    output logic [7:0]                 disp_data,
    output logic [ERR_W-1:0]           err_count,
    output logic                       busy
);

    localparam int CH_W  = idx_w(NUM_CH);
    localparam int REG_W = idx_w(NUM_REG);
    localparam int TMO_W = idx_w(TIMEOUT_CYC + 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [REG_W-1:0] REG_LAST = REG_W'(NUM_REG - 1);

    state_t state, state_nxt;

    logic [6:0]       rd_left;   // bytes still to send in READ_STREAM
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       a_data, b_data;

    logic [1:0] op;
    logic [5:0] arg;
    assign op  = rx_data[7:6];
    assign arg = rx_data[5:0];

    logic good, xfer, ch_ok, reg_ok, tmo_hit;
    assign good    = rx_valid & ~rx_parity_err;
    assign xfer    = tx_valid & tx_ready;
    assign ch_ok   = 32'(arg) < NUM_CH;
    assign reg_ok  = 32'(arg) < NUM_REG;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    logic [REG_W-1:0] reg_inc;
    assign reg_inc = (cur_reg == REG_LAST) ? '0 : cur_reg + 1'b1;

    logic [6:0] rd_n;
    assign rd_n = (arg == 6'd0) ? 7'(NUM_REG) : {1'b0, arg};

    // Output-decode strobes
    logic wr_en, cmd_err, tmo_err, do_sel_ch, do_sel_reg, do_read, stream_xfer;
`ifdef WRITE_ACK_EN
    logic ack_done;
`endif
    logic err_inc;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (good && op == OP_WRITE)     state_nxt = ST_WAIT_DATA;
                else if (good && op == OP_READ) state_nxt = ST_READ_STREAM;
            end
            ST_WAIT_DATA: begin
                // A parity-bad byte aborts without writing.
                if (rx_valid) begin
`ifdef WRITE_ACK_EN
                    state_nxt = good ? ST_WRITE_ACK : ST_IDLE;
`else
                    state_nxt = ST_IDLE;
`endif
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ_STREAM: begin
                if (xfer && rd_left == 7'd1) state_nxt = ST_IDLE;
            end
`ifdef WRITE_ACK_EN
            ST_WRITE_ACK: begin
                if (xfer) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy        = 1'b0;
        wr_en       = 1'b0;
        cmd_err     = 1'b0;
        tmo_err     = 1'b0;
        do_sel_ch   = 1'b0;
        do_sel_reg  = 1'b0;
        do_read     = 1'b0;
        stream_xfer = 1'b0;
`ifdef WRITE_ACK_EN
        ack_done    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (good) begin
                    case (op)
                        OP_SEL_CH:  if (ch_ok)  do_sel_ch  = 1'b1; else cmd_err = 1'b1;
                        OP_SEL_REG: if (reg_ok) do_sel_reg = 1'b1; else cmd_err = 1'b1;
                        OP_READ:    do_read = 1'b1;
                        default:    ;
                    endcase
                end
            end
            ST_WAIT_DATA: begin
                wr_en   = good;
                tmo_err = ~rx_valid & tmo_hit;
            end
            ST_READ_STREAM: begin
                busy        = 1'b1;
                stream_xfer = xfer;
            end
`ifdef WRITE_ACK_EN
            ST_WRITE_ACK: begin
                busy     = 1'b1;
                ack_done = xfer;
            end
`endif
            default: ;
        endcase
    end

    // All error sources OR together so a cycle adds at most one.
    assign err_inc = (rx_valid & rx_parity_err) | (rx_valid & busy) | cmd_err | tmo_err;

    // ---- datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch    <= '0;
            cur_reg   <= '0;
            disp_ch   <= '0;
            disp_reg  <= '0;
            disp_data <= '0;
            err_count <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            rd_left   <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (err_inc && err_count != '1)
                err_count <= err_count + 1'b1;

            // Counter sits at 0 outside WAIT_DATA, so every entry starts fresh.
            if (state != ST_WAIT_DATA) tmo_cnt <= '0;
            else if (!tmo_hit)         tmo_cnt <= tmo_cnt + 1'b1;

            if (do_sel_ch) begin
                cur_ch  <= arg[CH_W-1:0];
                cur_reg <= '0;
            end
            if (do_sel_reg)
                cur_reg <= arg[REG_W-1:0];

            if (do_read) begin
                tx_data  <= a_data;
                tx_valid <= 1'b1;
                rd_left  <= rd_n;
            end

            if (wr_en) begin
                cur_reg <= reg_inc;
`ifdef WRITE_ACK_EN
                tx_data  <= rx_data;
                tx_valid <= 1'b1;
`endif
            end

            // Port A already looks at cur_reg+1 while streaming, so the next
            // byte loads on the accepting edge with no bubble.
            if (stream_xfer) begin
                cur_reg <= reg_inc;
                if (rd_left == 7'd1) begin
                    tx_valid <= 1'b0;
                end else begin
                    tx_data <= a_data;
                    rd_left <= rd_left - 1'b1;
                end
            end

`ifdef WRITE_ACK_EN
            if (ack_done)
                tx_valid <= 1'b0;
`endif

            if (btn_next) begin
                if (browse_reg) disp_reg <= (disp_reg == REG_LAST) ? '0 : disp_reg + 1'b1;
                else            disp_ch  <= (disp_ch == CH_LAST)   ? '0 : disp_ch + 1'b1;
            end

            disp_data <= b_data;
        end
    end

    chan_regfile #(
        .NUM_CH  (NUM_CH),
        .NUM_REG (NUM_REG),
        .CH_W    (CH_W),
        .REG_W   (REG_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .wr_ch   (cur_ch),
        .wr_reg  (cur_reg),
        .wr_data (rx_data),
        .a_ch    (cur_ch),
        .a_reg   ((state == ST_READ_STREAM) ? reg_inc : cur_reg),
        .a_data  (a_data),
        .b_ch    (disp_ch),
        .b_reg   (disp_reg),
        .b_data  (b_data)
    );

endmodule

// File: tb/tb_chan_cmd_processor.sv
// Directed self-checking bench for chan_cmd_processor (NUM_CH=4, NUM_REG=8,
// short TIMEOUT_CYC). Inputs change on the falling edge; outputs are sampled
// on the falling edge as well.
module tb_chan_cmd_processor;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       btn_next, browse_reg;
    logic [1:0] cur_ch, disp_ch;
    logic [2:0] cur_reg, disp_reg;
    logic [7:0] disp_data;
    logic [7:0] err_count;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chan_cmd_processor #(
        .NUM_CH(4), .NUM_REG(8), .TIMEOUT_CYC(TMO), .ERR_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .btn_next(btn_next), .browse_reg(browse_reg),
        .cur_ch(cur_ch), .cur_reg(cur_reg),
        .disp_ch(disp_ch), .disp_reg(disp_reg), .disp_data(disp_data),
        .err_count(err_count), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1; rx_parity_err = pe;
        @(negedge clk);
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    // Write data byte; with the ack feature the echo is accepted straight away.
    task automatic write_byte(input logic [7:0] b);
        send_byte(b, 1'b0);
`ifdef WRITE_ACK_EN
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
`endif
    endtask

    task automatic pulse_btn(input logic br);
        @(negedge clk);
        browse_reg = br; btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
    endtask

    logic [7:0] got [3];
    int         nrx, unstable, busy_bad, first_ok;
    logic       pv, pr;
    logic [7:0] pd;

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_parity_err = 1'b0;
        tx_ready = 1'b0; btn_next = 1'b0; browse_reg = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_cur_ch",   32'(cur_ch),    32'd0);
        chk("rst_cur_reg",  32'(cur_reg),   32'd0);
        chk("rst_err",      32'(err_count), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid),  32'd0);
        chk("rst_tx_data",  32'(tx_data),   32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_disp",     32'({disp_ch, disp_reg, disp_data}), 32'd0);

        // SEL_CH 1, write 0xAB -> regs[1][0]
        send_byte(8'h41, 1'b0);
        chk("selch1", 32'(cur_ch), 32'd1);
        send_byte(8'h00, 1'b0);
        write_byte(8'hAB);
        chk("wr1_cur_reg", 32'(cur_reg),   32'd1);
        chk("wr1_err",     32'(err_count), 32'd0);
        chk("wr1_tx_idle", 32'(tx_valid),  32'd0);

        // channel 2: [2][1]=11 [2][2]=22 [2][7]=33 [2][0]=44
        send_byte(8'h42, 1'b0);
        chk("selch2_reg0", 32'(cur_reg), 32'd0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h00, 1'b0); write_byte(8'h11);
        send_byte(8'h00, 1'b0); write_byte(8'h22);
        chk("wr_inc", 32'(cur_reg), 32'd3);
        send_byte(8'h87, 1'b0);
        chk("selreg7", 32'(cur_reg), 32'd7);
        send_byte(8'h00, 1'b0); write_byte(8'h33);
        chk("reg_wrap", 32'(cur_reg), 32'd0);
        send_byte(8'h00, 1'b0); write_byte(8'h44);
        chk("wr_after_wrap", 32'(cur_reg), 32'd1);

        // READ 3 from reg 0 with tx_ready high one cycle in three; overrun at cyc 4
        send_byte(8'h80, 1'b0);
        @(negedge clk);
        rx_data = 8'hC3; rx_valid = 1'b1;
        nrx = 0; unstable = 0; busy_bad = 0; first_ok = 0; pv = 1'b0; pr = 1'b0; pd = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            rx_valid = (cyc == 4); rx_parity_err = (cyc == 4); rx_data = 8'h55;
            tx_ready = ((cyc % 3) == 2);
            if (cyc == 0 && tx_valid === 1'b1 && tx_data === 8'h44) first_ok = 1;
            if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) unstable++;
            if (tx_valid && busy !== 1'b1) busy_bad++;
            if (tx_valid && tx_ready) begin
                if (nrx < 3) got[nrx] = tx_data;
                nrx++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
        end
        tx_ready = 1'b0; rx_valid = 1'b0; rx_parity_err = 1'b0;
        chk("rd_first_latency", 32'(first_ok), 32'd1);
        chk("rd_count",   32'(nrx),    32'd3);
        chk("rd_byte0",   32'(got[0]), 32'h44);
        chk("rd_byte1",   32'(got[1]), 32'h11);
        chk("rd_byte2",   32'(got[2]), 32'h22);
        chk("rd_stable",  32'(unstable), 32'd0);
        chk("rd_busy",    32'(busy_bad), 32'd0);
        chk("rd_overrun", 32'(err_count), 32'd1);
        chk("rd_done",    32'({tx_valid, busy}), 32'd0);
        chk("rd_cur_reg", 32'(cur_reg), 32'd3);

        // out-of-range channel and a parity-bad byte
        send_byte(8'h45, 1'b0);
        chk("bad_ch_keep", 32'(cur_ch),    32'd2);
        chk("bad_ch_err",  32'(err_count), 32'd2);
        send_byte(8'h41, 1'b1);
        chk("par_keep", 32'(cur_ch),    32'd2);
        chk("par_err",  32'(err_count), 32'd3);

        // WAIT_DATA timeout boundary, then 0x99 = SEL_REG 25 (bad)
        send_byte(8'h00, 1'b0);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_before", 32'(err_count), 32'd3);
        @(negedge clk);
        chk("tmo_at", 32'(err_count), 32'd4);
        send_byte(8'h99, 1'b0);
        chk("tmo_99_err",   32'(err_count), 32'd5);
        chk("tmo_no_write", 32'(cur_reg),   32'd3);

        // browse: ch +1, reg +2
        pulse_btn(1'b0);
        chk("br_ch", 32'(disp_ch), 32'd1);
        @(negedge clk);
        chk("br_data_10", 32'(disp_data), 32'hAB);
        pulse_btn(1'b1);
        pulse_btn(1'b1);
        chk("br_reg", 32'(disp_reg), 32'd2);
        @(negedge clk);
        chk("br_data_12", 32'(disp_data), 32'h00);

        // write 0x5A into the displayed register [1][2]
        send_byte(8'h41, 1'b0);
        send_byte(8'h82, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
`ifdef WRITE_ACK_EN
        chk("ack_valid", 32'(tx_valid), 32'd1);
        chk("ack_data",  32'(tx_data),  32'h5A);
        chk("ack_busy",  32'(busy),     32'd1);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("ack_done", 32'({tx_valid, busy}), 32'd0);
`else
        chk("noack_tx", 32'({tx_valid, busy}), 32'd0);
`endif
        @(negedge clk);
        chk("disp_follow_wr", 32'(disp_data), 32'h5A);
        chk("wr5a_cur_reg",   32'(cur_reg),   32'd3);

        // saturation: 5 + 250 = 255, then stays
        for (int i = 0; i < 250; i++) send_byte(8'h00, 1'b1);
        chk("sat_reach", 32'(err_count), 32'd255);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("sat_hold", 32'(err_count), 32'd255);

        // reset mid-stream
        send_byte(8'hC0, 1'b0);
        chk("stream_up", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop", 32'(tx_valid), 32'd0);
        rst = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        chk("rst_quiet", 32'(tx_valid), 32'd0);
        chk("rst_state", 32'({cur_ch, cur_reg, err_count}), 32'd0);
        pulse_btn(1'b0);
        pulse_btn(1'b1);
        pulse_btn(1'b1);
        @(negedge clk);
        chk("rst_cleared_reg", 32'(disp_data), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
